stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Control sequencer for the stopwatch counter datapath. Conditions three raw
//  active-low pushbuttons (start/stop, lap, clear) and generates the 1 kHz count
//  tick. Runs the IDLE/RUN/PAUSE/LAP state machine and drives the datapath with
//  count enable, synchronous clear and display-hold strobes.
//  Sits between the board KEY inputs and the BCD digit counter/display registers.
// PARAMETERS
//  CLK_HZ     50_000_000  input clock frequency
//  TICK_HZ    1000        tick rate (one ms digit step per tick)
//  DB_CYCLES  500_000     clk cycles a synced button level must be stable to be accepted
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-high reset
//  btn_ss_n    in   1  raw start/stop button, active-low, asynchronous
//  btn_lap_n   in   1  raw lap button, active-low, asynchronous
//  btn_clr_n   in   1  raw clear button, active-low, asynchronous
//  tick        out  1  free-running 1-cycle pulse at TICK_HZ
//  count_en    out  1  1-cycle increment strobe to digit counters
//  count_clr   out  1  1-cycle synchronous clear strobe to digit counters
//  disp_hold   out  1  1 = display registers frozen (lap view)
//  state       out  2  current FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
// BEHAVIOUR
//  Reset (async assert):
//  - tick, count_en, count_clr, disp_hold = 0; state = IDLE.
//  - Divider = 0; debounce counters = 0; debounced levels = 1 (released).
//  Reset release: synchronous to clk.
//  Divider:
//  - DIV = CLK_HZ/TICK_HZ; counter 0..DIV-1, wraps to 0.
//  - tick registered high for the cycle after counter == DIV-1; period exactly DIV.
//  - Runs in all states, never held or reset by the FSM.
//  Button conditioning, per button:
//  - 2-FF synchronizer, then debounce: counter resets on any change of the synced
//    level; debounced level updates when the same level has been seen DB_CYCLES cycles.
//  - Press event = 1-cycle pulse on debounced 1->0. Release generates nothing.
//  - Raw edge to event pulse: 2 + DB_CYCLES + 1 cycles.
//  - Glitch shorter than DB_CYCLES: no event.
//  FSM: transition on the clk edge where the event pulse is high.
//  - Event priority in the same cycle: clr > ss > lap; lower events that cycle are dropped.
//  - IDLE:  ss -> RUN; clr -> IDLE + count_clr; lap ignored.
//  - RUN:   ss -> PAUSE; lap -> LAP; clr ignored.
//  - PAUSE: ss -> RUN; clr -> IDLE + count_clr; lap ignored.
//  - LAP:   lap -> RUN; ss -> PAUSE; clr ignored.
//  Outputs:
//  - count_en = tick AND state in {RUN,LAP}, registered: 1 cycle after tick, 1 cycle wide.
//  - Tick coincident with the transition edge uses the old state.
//  - count_clr: registered 1-cycle pulse the cycle after an accepted clr event.
//  - count_clr forces count_en low that same cycle.
//  - disp_hold = 1 exactly while state == LAP; counting continues underneath.
//  - Leaving LAP (either path) drops disp_hold with the state change.
//  Reset mid-press or mid-debounce: event discarded, state IDLE.
//  Button still held at reset release reads as released until debounced low.
//  No event is produced from that held button.
// TESTING  (CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DB_CYCLES=4)
//  1 Reset, no buttons, 100 cycles -> tick every 10 cycles; count_en=0; state=00.
//  2 ss pressed 20 cycles -> state 01 at cycle 7 after edge; count_en pulses once per tick.
//  3 ss glitch low 3 cycles -> no event; state unchanged.
//  4 RUN, lap press -> state 11, disp_hold=1, count_en still pulsing.
//  4 (cont.) lap again -> state 01, disp_hold=0.
//  5 PAUSE, clr and ss pressed same cycle -> state 00; one count_clr pulse; count_en=0.
//  6 Assert reset during RUN, mid-debounce of lap -> all outputs 0, state 00.
//  6 (cont.) After release, no lap event; first tick DIV cycles later.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: tick divider, pushbutton conditioning and the
// IDLE/RUN/PAUSE/LAP state machine that drives the digit counter datapath.
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss_n,
    input  logic       btn_lap_n,
    input  logic       btn_clr_n,
    output logic       tick,
    output logic       count_en,
    output logic       count_clr,
    output logic       disp_hold,
    output logic [1:0] state
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DbW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StLap   = 2'b11
    } state_e;

    logic [DivW-1:0] div_q;
    logic            tick_q;

    // Button bit order: 0 = start/stop, 1 = lap, 2 = clear.
    logic [2:0]     btn_raw_n;
    logic [2:0]     sync1_q;
    logic [2:0]     sync2_q;
    logic [2:0]     db_level_q;
    logic [2:0]     db_prev_q;
    logic [2:0]     armed_q;
    logic [2:0]     press;
    logic [DbW-1:0] db_cnt_q [3];
    logic [1:0]     fill_q;
    logic           fill_done;

    state_e state_q, state_d;
    logic   count_en_q, count_en_d;
    logic   count_clr_q, count_clr_d;
    logic   ev_ss, ev_lap, ev_clr;

    assign btn_raw_n = {btn_clr_n, btn_lap_n, btn_ss_n};

    // Free-running tick divider; never touched by the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (div_q == DivLast);
            div_q  <= (div_q == DivLast) ? '0 : div_q + DivW'(1);
        end
    end

    // Synchronized level only reflects the pins after both flops have refilled.
    assign fill_done = (fill_q == 2'd2);

    // Synchronize, debounce and arm each button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            db_level_q <= '1;
            db_prev_q  <= '1;
            armed_q    <= '0;
            fill_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw_n;
            sync2_q   <= sync1_q;
            db_prev_q <= db_level_q;
            if (!fill_done) begin
                fill_q <= fill_q + 2'd1;
            end else begin
                // A button held through reset never arms until seen released.
                armed_q <= armed_q | sync2_q;
            end
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == db_level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbLast) begin
                    db_cnt_q[i]   <= '0;
                    db_level_q[i] <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    assign press  = armed_q & db_prev_q & ~db_level_q;
    assign ev_ss  = press[0];
    assign ev_lap = press[1];
    assign ev_clr = press[2];

    // Next state and strobes; events ignored in a state do not block lower ones.
    always_comb begin
        state_d     = state_q;
        count_clr_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev_clr) begin
                    count_clr_d = 1'b1;
                end else if (ev_ss) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (ev_ss) begin
                    state_d = StPause;
                end else if (ev_lap) begin
                    state_d = StLap;
                end
            end
            StPause: begin
                if (ev_clr) begin
                    state_d     = StIdle;
                    count_clr_d = 1'b1;
                end else if (ev_ss) begin
                    state_d = StRun;
                end
            end
            StLap: begin
                if (ev_ss) begin
                    state_d = StPause;
                end else if (ev_lap) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
        // Uses the pre-transition state so a coincident tick still counts.
        count_en_d = tick_q && ((state_q == StRun) || (state_q == StLap)) && !count_clr_d;
    end

    // State and output strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
        end
    end

    assign tick      = tick_q;
    assign count_en  = count_en_q;
    assign count_clr = count_clr_q;
    assign disp_hold = (state_q == StLap);
    assign state     = state_q;

endmodule
